// File: rtl/mult_pkg.sv
//==============================================================================
// Module      : mult_pkg
// Description : Shared widths and controller state encodings for the
//               sequential 8x8 shift-add multiplier.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/gen_product.sv
//==============================================================================
// Module      : gen_product
// Description : One partial product: multiplicand gated by a multiplier bit,
//               zero-extended to product width and shifted into position.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gen_product
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]   X,
  input  logic              Y_bit,
  input  logic [CNT_W-1:0]  Shift,
  output logic [PROD_W-1:0] PP
);

  logic [PROD_W-1:0] w_ext;

  assign w_ext = {{(PROD_W-OP_W){1'b0}}, X};
  assign PP    = Y_bit ? (w_ext << Shift) : '0;

endmodule

`default_nettype wire

// File: rtl/mult_8bit_seq.sv
//==============================================================================
// Module      : mult_8bit_seq
// Description : Sequential 8x8 unsigned shift-add multiplier with valid/ready
//               handshakes on operands and product, one multiplier bit/cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mult_8bit_seq
  import mult_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   X,
  input  logic [OP_W-1:0]   Y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] P,
  output logic              busy
);

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(OP_W - 1);

  state_t              r_state;
  logic [OP_W-1:0]     r_x;
  logic [OP_W-1:0]     r_y;
  logic [PROD_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;

  logic [PROD_W-1:0]   w_pp;
  logic [PROD_W-1:0]   w_acc_next;
  logic [OP_W-1:0]     w_y_shift;
  logic                w_exit;

  gen_product u_gen_product (
    .X     (r_x),
    .Y_bit (r_y[0]),
    .Shift (r_cnt),
    .PP    (w_pp)
  );

  assign in_ready   = (r_state == IDLE);
  assign w_acc_next = r_acc + w_pp;
  assign w_y_shift  = r_y >> 1;
  // Early exit looks at the multiplier after this cycle's shift: nothing left to add.
  assign w_exit     = (r_cnt == C_LAST_BIT) || (EARLY_EXIT && (w_y_shift == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      P         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= X;
            r_y     <= Y;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_y   <= w_y_shift;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_exit) begin
            P         <= w_acc_next;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
